controle_memoria_dados: RTL and testbench

// Load/store controller directly upstream of the data RAM. Accepts one memory request at a time from the

---
 rtl/controle_memoria_dados.sv | 225 ++++++++++++++++++++++
 tb/tb_controle_memoria_dados.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/controle_memoria_dados.sv
// controle_memoria_dados
// Load/store controller that sits directly in front of the data RAM.
// It takes one request at a time from the execute stage and drives the RAM ports.
// It performs byte/halfword/word loads with sign or zero extension.
// It builds sub-word stores by read-modify-write.
// It hides the RAM's registered read port and its registered bank-offset latch.
//
// Handshake: a request is accepted on a rising edge where req_valid & req_ready.
// req_ready is high only while idle (OCIOSO), and req_* are ignored otherwise.
// Completion is a one-cycle resp_valid pulse. erro_acesso and resp_rdata are
// meaningful only in that cycle. req_ready is already high during the pulse,
// so a new request may be accepted back-to-back.
//
// Ports:
//   clock, reset           single clock, asynchronous active-high reset
//   req_*                  request from pipeline (valid/ready, write, size, signed, banco, addr, wdata)
//   resp_valid/rdata       completion pulse, load data (0 for stores/errors)
//   erro_acesso            access error flag, qualified by resp_valid
//   ram_*                  RAM data, read/write word addresses, we, offset_register; ram_q from RAM
//   estado_dbg             current FSM state, for observation
module controle_memoria_dados #(
  parameter int ADDR_WIDTH     = 32,
  parameter int PALAVRAS_BANCO = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic                  req_banco,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  erro_acesso,
  output logic [31:0]           ram_data,
  output logic [ADDR_WIDTH-1:0] ram_end_leitura,
  output logic [ADDR_WIDTH-1:0] ram_end_escrita,
  output logic                  ram_we,
  output logic                  ram_offset_register,
  input  logic [31:0]           ram_q,
  output logic [2:0]            estado_dbg
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BANCO   = 3'd1,
    LEITURA = 3'd2,
    DADO    = 3'd3,
    ESCRITA = 3'd4
  } estado_t;

  estado_t                 estado_q, estado_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [1:0]              lane_q, lane_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   end_q, end_d;
  logic [31:0]             data_q, data_d;
  logic                    offset_q, offset_d;
  logic                    banco_valido_q, banco_valido_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    erro_q, erro_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    aceita;
  logic                    erro_req;
  logic                    troca_banco;
  logic                    palavra_store_req;
  logic [ADDR_WIDTH-1:0]   end_palavra;
  logic [31:0]             q_byte_desl;
  logic [31:0]             q_half_desl;
  logic [31:0]             dado_lido;
  logic [31:0]             mascara;
  logic [31:0]             dado_merge;

  assign req_ready           = (estado_q == OCIOSO);
  assign aceita              = req_valid & req_ready;
  assign end_palavra         = {2'b00, req_addr[ADDR_WIDTH-1:2]};
  assign erro_req            = (req_size == 2'b11)
                             | ((req_size == 2'b01) & req_addr[0])
                             | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                             | (end_palavra >= ADDR_WIDTH'(PALAVRAS_BANCO));
  // offset_q = 1 means the low bank is selected, so a request to bank b matches when b == ~offset_q.
  assign troca_banco         = ~banco_valido_q | (req_banco == offset_q);
  assign palavra_store_req   = req_write & (req_size == 2'b10);

  // Lane extraction for loads: shift the addressed byte/halfword down to bit 0.
  assign q_byte_desl = ram_q >> {lane_q, 3'b000};
  assign q_half_desl = ram_q >> {lane_q[1], 4'b0000};

  always_comb begin
    dado_lido = ram_q;
    mascara   = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        dado_lido = signed_q ? {{24{q_byte_desl[7]}}, q_byte_desl[7:0]} : {24'h0, q_byte_desl[7:0]};
        mascara   = 32'h0000_00FF << {lane_q, 3'b000};
      end
      2'b01: begin
        dado_lido = signed_q ? {{16{q_half_desl[15]}}, q_half_desl[15:0]} : {16'h0, q_half_desl[15:0]};
        mascara   = 32'h0000_FFFF << {lane_q[1], 4'b0000};
      end
      default: begin
        dado_lido = ram_q;
        mascara   = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Store merge: align the right-justified store data to the lane, keep the other bytes from ram_q.
  assign dado_merge = (ram_q & ~mascara)
                    | ((wdata_q << ((size_q == 2'b01) ? {lane_q[1], 4'b0000} : {lane_q, 3'b000})) & mascara);

  always_comb begin
    estado_d       = estado_q;
    write_d        = write_q;
    size_d         = size_q;
    signed_d       = signed_q;
    lane_d         = lane_q;
    wdata_d        = wdata_q;
    end_d          = end_q;
    data_d         = data_q;
    offset_d       = offset_q;
    banco_valido_d = banco_valido_q;
    resp_valid_d   = 1'b0;
    erro_d         = 1'b0;
    rdata_d        = rdata_q;
    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          if (erro_req) begin
            // Rejected without touching the RAM or the bank selection.
            resp_valid_d = 1'b1;
            erro_d       = 1'b1;
            rdata_d      = 32'h0;
          end else begin
            write_d  = req_write;
            size_d   = req_size;
            signed_d = req_signed;
            lane_d   = req_addr[1:0];
            wdata_d  = req_wdata;
            end_d    = end_palavra;
            if (palavra_store_req) data_d = req_wdata;
            if (troca_banco) begin
              offset_d = ~req_banco;
              estado_d = BANCO;
            end else begin
              estado_d = palavra_store_req ? ESCRITA : LEITURA;
            end
          end
        end
      end
      BANCO: begin
        // The RAM latches offset_register on this edge.
        banco_valido_d = 1'b1;
        estado_d       = (write_q && (size_q == 2'b10)) ? ESCRITA : LEITURA;
      end
      LEITURA: estado_d = DADO;
      DADO: begin
        if (write_q) begin
          data_d   = dado_merge;
          estado_d = ESCRITA;
        end else begin
          rdata_d      = dado_lido;
          resp_valid_d = 1'b1;
          estado_d     = OCIOSO;
        end
      end
      ESCRITA: begin
        rdata_d      = 32'h0;
        resp_valid_d = 1'b1;
        estado_d     = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      write_q        <= 1'b0;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      lane_q         <= 2'b00;
      wdata_q        <= 32'h0;
      end_q          <= '0;
      data_q         <= 32'h0;
      offset_q       <= 1'b1;
      banco_valido_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      erro_q         <= 1'b0;
      rdata_q        <= 32'h0;
    end else begin
      estado_q       <= estado_d;
      write_q        <= write_d;
      size_q         <= size_d;
      signed_q       <= signed_d;
      lane_q         <= lane_d;
      wdata_q        <= wdata_d;
      end_q          <= end_d;
      data_q         <= data_d;
      offset_q       <= offset_d;
      banco_valido_q <= banco_valido_d;
      resp_valid_q   <= resp_valid_d;
      erro_q         <= erro_d;
      rdata_q        <= rdata_d;
    end
  end

  // Write enable decoded from state so an asynchronous reset removes it at once.
  assign ram_we              = (estado_q == ESCRITA);
  assign ram_end_leitura     = end_q;
  assign ram_end_escrita     = end_q;
  assign ram_data            = data_q;
  assign ram_offset_register = offset_q;
  assign resp_valid          = resp_valid_q;
  assign erro_acesso         = erro_q;
  assign resp_rdata          = rdata_q;
  assign estado_dbg          = estado_q;

endmodule

// File: tb/tb_controle_memoria_dados.sv
module tb_controle_memoria_dados;

  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          req_valid, req_ready, req_write, req_signed, req_banco;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, erro_acesso;
  logic [31:0]   resp_rdata, ram_data, ram_q;
  logic [AW-1:0] ram_end_leitura, ram_end_escrita;
  logic          ram_we, ram_offset_register;
  logic [2:0]    estado_dbg;

  controle_memoria_dados #(.ADDR_WIDTH(AW), .PALAVRAS_BANCO(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_banco(req_banco),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .erro_acesso(erro_acesso),
    .ram_data(ram_data), .ram_end_leitura(ram_end_leitura), .ram_end_escrita(ram_end_escrita),
    .ram_we(ram_we), .ram_offset_register(ram_offset_register), .ram_q(ram_q),
    .estado_dbg(estado_dbg)
  );

  // ---------------- RAM model: registered read, registered bank-offset latch ----------------
  logic [31:0] ram_mem [0:127];
  logic        ram_off_lat;
  logic        ram_clear;
  always @(posedge clock) begin
    if (ram_clear) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= 32'h0;
    end else begin
      if (ram_we) ram_mem[{~ram_off_lat, ram_end_escrita[5:0]}] <= ram_data;
      ram_q <= ram_mem[{~ram_off_lat, ram_end_leitura[5:0]}];
    end
    ram_off_lat <= ram_offset_register;
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]  ref_mem [0:511];   // byte-addressed: bank*256 + byte address
  bit          ref_bv;
  bit          ref_bank;
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic bk,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        err;
    int          exp_lat, exp_we, lat, we_cnt, base, ba;
    logic [31:0] exp_word, exp_rd, got_rd;
    logic [7:0]  b0;
    logic [15:0] h0;
    bit          got;
    err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)
          || (addr >= 32'h100);
    exp_word = 32'h0;
    exp_rd   = 32'h0;
    exp_we   = 0;
    if (err) begin
      exp_lat = 1;
    end else begin
      ba   = int'(bk) * 256 + int'(addr[7:0]);
      base = int'(bk) * 256 + int'({addr[7:2], 2'b00});
      if (w) exp_lat = (sz == 2'b10) ? 2 : 4;
      else   exp_lat = 3;
      if (!ref_bv || ref_bank != bk) exp_lat++;
      ref_bv   = 1'b1;
      ref_bank = bk;
      if (w) begin
        exp_we = 1;
        ref_mem[ba] = wd[7:0];
        if (sz != 2'b00) ref_mem[ba + 1] = wd[15:8];
        if (sz == 2'b10) begin
          ref_mem[ba + 2] = wd[23:16];
          ref_mem[ba + 3] = wd[31:24];
        end
      end else begin
        b0 = ref_mem[ba];
        h0 = {ref_mem[ba + 1], ref_mem[ba]};
        case (sz)
          2'b00:   exp_rd = sg ? {{24{b0[7]}}, b0} : {24'h0, b0};
          2'b01:   exp_rd = sg ? {{16{h0[15]}}, h0} : {16'h0, h0};
          default: exp_rd = {ref_mem[ba + 3], ref_mem[ba + 2], ref_mem[ba + 1], ref_mem[ba]};
        endcase
      end
      exp_word = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    end
    exp_q.push_back(exp_rd);

    @(negedge clock);
    check_eq("pulse_one_cycle", {31'h0, resp_valid}, 32'h0);
    check_eq("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_write = w; req_size = sz; req_signed = sg; req_banco = bk;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clock);
    got = 1'b0; lat = 0; we_cnt = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      req_wdata = $urandom;      // must be ignored after accept
      req_addr  = $urandom;
      if (ram_we) begin
        we_cnt++;
        check_eq("we_addr", ram_end_escrita, addr >> 2);
        check_eq("we_data", ram_data, exp_word);
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    got_rd = exp_q.pop_front();
    if (!got) begin
      check_eq("resp_timeout", {31'h0, resp_valid}, 32'h1);
    end else begin
      check_eq("latency", lat, exp_lat);
      check_eq("erro_acesso", {31'h0, erro_acesso}, {31'h0, err});
      check_eq("resp_rdata", resp_rdata, got_rd);
      check_eq("we_count", we_cnt, exp_we);
      if (!err) check_eq("offset_reg", {31'h0, ram_offset_register}, {31'h0, ~bk});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h0;
    ref_bv = 1'b0; ref_bank = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_banco = 1'b0; req_addr = '0; req_wdata = 32'h0;
    reset = 1'b1; ram_clear = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("rst_we", {31'h0, ram_we}, 32'h0);
    check_eq("rst_offset", {31'h0, ram_offset_register}, 32'h1);
    check_eq("rst_data", ram_data, 32'h0);
    check_eq("rst_rd_addr", ram_end_leitura, 32'h0);
    check_eq("rst_state", {29'h0, estado_dbg}, 32'h0);
    reset = 1'b0; ram_clear = 1'b0;

    // Directed scenarios: word store/load, lane extraction, sub-word store, errors, bank switching.
    do_req(1'b1, 2'b10, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 1'b0, 32'h13, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 1'b0, 32'h12, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 1'b0, 32'h11, 32'h0000_0055);
    do_req(1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 1'b0, 32'h11, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 1'b0, 32'h100, 32'h1234_5678);
    do_req(1'b1, 2'b10, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
    do_req(1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'b01, 1'b1, 1'b1, 32'h12, 32'h0);

    // Reset asserted during ESCRITA: ram_we must drop without waiting for a clock edge.
    @(negedge clock);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_banco = 1'b1;
    req_addr = 32'h20; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check_eq("esc_we_before_reset", {31'h0, ram_we}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_we_drop", {31'h0, ram_we}, 32'h0);
    check_eq("async_state", {29'h0, estado_dbg}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    ref_bv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("no_resp_after_reset", {31'h0, resp_valid}, 32'h0);
    end
    do_req(1'b0, 2'b10, 1'b0, 1'b1, 32'h20, 32'h0);

    // Randomized traffic against the byte-level reference model.
    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h10F)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "time limit");
  end

endmodule
